// File: rtl/smc_timing_counter5.sv
`default_nettype none
// ============================================================================
//  Module   : smc_timing_counter5
//  Purpose  : Access-timing counter stage for the SMC state machine. Captures
//             per-access timing config when an access is accepted, then runs
//             the CS leading-edge, wait-state and CS trailing-edge
//             down-counters under the state machine's enables.
//  Options  : SMC_EXT_WAIT_EN - adds smc_n_ext_wait5, which stretches the
//             final wait state while external wait is asserted (low).
//  Revision : 1.0 - initial release
// ============================================================================
module smc_timing_counter5 #(
    parameter int WS_W   = 8,
    parameter int EDGE_W = 2
) (
    input  logic              sys_clk5,
    input  logic              n_sys_reset5,
    input  logic              valid_access5,
    input  logic              le_enable5,
    input  logic              ws_enable5,
    input  logic              cste_enable5,
    input  logic              smc_done5,
    input  logic              mac_done5,
    input  logic              n_read5,
`ifdef SMC_EXT_WAIT_EN
    input  logic              smc_n_ext_wait5,
`endif
    input  logic [EDGE_W-1:0] csle_cfg5,
    input  logic [EDGE_W-1:0] cste_cfg5,
    input  logic [EDGE_W-1:0] oete_cfg5,
    input  logic [WS_W-1:0]   wsr_cfg5,
    input  logic [WS_W-1:0]   wsw_cfg5,
    output logic [EDGE_W-1:0] r_csle_count5,
    output logic [EDGE_W-1:0] r_cste_count5,
    output logic [WS_W-1:0]   r_ws_count5,
    output logic [EDGE_W-1:0] r_csle_store5,
    output logic [EDGE_W-1:0] r_oete_store5
);

    logic [EDGE_W-1:0] csle_count_q, csle_count_d;
    logic [EDGE_W-1:0] cste_count_q, cste_count_d;
    logic [WS_W-1:0]   ws_count_q,   ws_count_d;
    logic [EDGE_W-1:0] csle_store_q, csle_store_d;
    logic [EDGE_W-1:0] cste_store_q, cste_store_d;
    logic [EDGE_W-1:0] oete_store_q, oete_store_d;
    logic [WS_W-1:0]   ws_store_q,   ws_store_d;

    // Wait-state value for the access currently being accepted.
    logic [WS_W-1:0]   w_ws_sel;
    // Next beat of a multiple access is starting: reload edge counters.
    logic              w_next_beat;
    // External wait pins the wait counter at its last state.
    logic              w_ws_hold;

    assign w_ws_sel    = n_read5 ? wsw_cfg5 : wsr_cfg5;
    assign w_next_beat = smc_done5 & ~mac_done5;

`ifdef SMC_EXT_WAIT_EN
    assign w_ws_hold   = ~smc_n_ext_wait5 & (ws_count_q == WS_W'(1));
`else
    assign w_ws_hold   = 1'b0;
`endif

    // Next-state logic: config stores and the three saturating down-counters.
    always_comb begin
        csle_store_d = csle_store_q;
        cste_store_d = cste_store_q;
        oete_store_d = oete_store_q;
        ws_store_d   = ws_store_q;
        if (valid_access5) begin
            csle_store_d = csle_cfg5;
            cste_store_d = cste_cfg5;
            oete_store_d = oete_cfg5;
            ws_store_d   = w_ws_sel;
        end

        // A new access always beats a next-beat reload on the same cycle.
        csle_count_d = csle_count_q;
        if (valid_access5) begin
            csle_count_d = csle_cfg5;
        end else if (w_next_beat) begin
            csle_count_d = csle_store_q;
        end else if (le_enable5 && (csle_count_q != '0)) begin
            csle_count_d = csle_count_q - EDGE_W'(1);
        end

        // Load bypasses the store when the access is accepted on this cycle.
        ws_count_d = ws_count_q;
        if (ws_enable5) begin
            ws_count_d = valid_access5 ? w_ws_sel : ws_store_q;
        end else if ((ws_count_q != '0) && !w_ws_hold) begin
            ws_count_d = ws_count_q - WS_W'(1);
        end

        cste_count_d = cste_count_q;
        if (valid_access5) begin
            cste_count_d = cste_cfg5;
        end else if (w_next_beat) begin
            cste_count_d = cste_store_q;
        end else if (cste_enable5 && (cste_count_q != '0)) begin
            cste_count_d = cste_count_q - EDGE_W'(1);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge sys_clk5 or negedge n_sys_reset5) begin
        if (!n_sys_reset5) begin
            csle_count_q <= '0;
            cste_count_q <= '0;
            ws_count_q   <= '0;
            csle_store_q <= '0;
            cste_store_q <= '0;
            oete_store_q <= '0;
            ws_store_q   <= '0;
        end else begin
            csle_count_q <= csle_count_d;
            cste_count_q <= cste_count_d;
            ws_count_q   <= ws_count_d;
            csle_store_q <= csle_store_d;
            cste_store_q <= cste_store_d;
            oete_store_q <= oete_store_d;
            ws_store_q   <= ws_store_d;
        end
    end

    assign r_csle_count5 = csle_count_q;
    assign r_cste_count5 = cste_count_q;
    assign r_ws_count5   = ws_count_q;
    assign r_csle_store5 = csle_store_q;
    assign r_oete_store5 = oete_store_q;

endmodule
`default_nettype wire

// File: tb/tb_smc_timing_counter5.sv
`default_nettype none
// ============================================================================
//  Module   : tb_smc_timing_counter5
//  Purpose  : Self-checking bench for smc_timing_counter5 (directed scenarios
//             plus randomized traffic against a behavioural model).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_smc_timing_counter5;

    logic       sys_clk5 = 1'b0;
    logic       n_sys_reset5;
    logic       valid_access5, le_enable5, ws_enable5, cste_enable5;
    logic       smc_done5, mac_done5, n_read5, smc_n_ext_wait5;
    logic [1:0] csle_cfg5, cste_cfg5, oete_cfg5;
    logic [7:0] wsr_cfg5, wsw_cfg5;
    logic [1:0] r_csle_count5, r_cste_count5, r_csle_store5, r_oete_store5;
    logic [7:0] r_ws_count5;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state (plain integers).
    int m_csle, m_cste, m_ws, m_csle_st, m_cste_st, m_oete_st, m_ws_st;

    smc_timing_counter5 #(.WS_W(8), .EDGE_W(2)) dut (
        .sys_clk5        (sys_clk5),
        .n_sys_reset5    (n_sys_reset5),
        .valid_access5   (valid_access5),
        .le_enable5      (le_enable5),
        .ws_enable5      (ws_enable5),
        .cste_enable5    (cste_enable5),
        .smc_done5       (smc_done5),
        .mac_done5       (mac_done5),
        .n_read5         (n_read5),
`ifdef SMC_EXT_WAIT_EN
        .smc_n_ext_wait5 (smc_n_ext_wait5),
`endif
        .csle_cfg5       (csle_cfg5),
        .cste_cfg5       (cste_cfg5),
        .oete_cfg5       (oete_cfg5),
        .wsr_cfg5        (wsr_cfg5),
        .wsw_cfg5        (wsw_cfg5),
        .r_csle_count5   (r_csle_count5),
        .r_cste_count5   (r_cste_count5),
        .r_ws_count5     (r_ws_count5),
        .r_csle_store5   (r_csle_store5),
        .r_oete_store5   (r_oete_store5)
    );

    always #5 sys_clk5 = ~sys_clk5;

    function automatic int dec_sat(input int v);
        return (v > 0) ? v - 1 : 0;
    endfunction

    function automatic logic [15:0] exp_vec();
        logic [1:0] a, b, c, d;
        logic [7:0] w;
        a = m_csle[1:0]; b = m_cste[1:0]; w = m_ws[7:0];
        c = m_csle_st[1:0]; d = m_oete_st[1:0];
        return {a, b, w, c, d};
    endfunction

    function automatic logic [15:0] act_vec();
        return {r_csle_count5, r_cste_count5, r_ws_count5, r_csle_store5, r_oete_store5};
    endfunction

    task automatic model_clear();
        m_csle = 0; m_cste = 0; m_ws = 0;
        m_csle_st = 0; m_cste_st = 0; m_oete_st = 0; m_ws_st = 0;
    endtask

    // Apply one clock of the access-timing rules to the model.
    task automatic model_edge();
        int sel, n_csle, n_cste, n_ws;
        bit ext_hold;
        if (!n_sys_reset5) begin
            model_clear();
            return;
        end
        sel = n_read5 ? int'(wsw_cfg5) : int'(wsr_cfg5);
        ext_hold = 1'b0;
`ifdef SMC_EXT_WAIT_EN
        ext_hold = (smc_n_ext_wait5 == 1'b0) && (m_ws == 1);
`endif
        if (valid_access5)                 n_csle = csle_cfg5;
        else if (smc_done5 && !mac_done5)  n_csle = m_csle_st;
        else if (le_enable5)               n_csle = dec_sat(m_csle);
        else                               n_csle = m_csle;

        if (valid_access5)                 n_cste = cste_cfg5;
        else if (smc_done5 && !mac_done5)  n_cste = m_cste_st;
        else if (cste_enable5)             n_cste = dec_sat(m_cste);
        else                               n_cste = m_cste;

        if (ws_enable5)                    n_ws = valid_access5 ? sel : m_ws_st;
        else if (ext_hold)                 n_ws = m_ws;
        else                               n_ws = dec_sat(m_ws);

        if (valid_access5) begin
            m_csle_st = csle_cfg5; m_cste_st = cste_cfg5;
            m_oete_st = oete_cfg5; m_ws_st   = sel;
        end
        m_csle = n_csle; m_cste = n_cste; m_ws = n_ws;
    endtask

    task automatic idle_inputs();
        valid_access5 = 0; le_enable5 = 0; ws_enable5 = 0; cste_enable5 = 0;
        smc_done5 = 0; mac_done5 = 0; n_read5 = 0; smc_n_ext_wait5 = 1;
    endtask

    // Advance one clock, update the model at the edge, settle 1 time unit.
    task automatic tick();
        @(posedge sys_clk5);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        csle_cfg5 = 0; cste_cfg5 = 0; oete_cfg5 = 0; wsr_cfg5 = 0; wsw_cfg5 = 0;
        n_sys_reset5 = 0;
        model_clear();
        tick();
        checks++;
        if (act_vec() !== 16'h0) begin
            failures++;
            $display("FAIL reset_initial actual=%h expected=0000", act_vec());
        end
        n_sys_reset5 = 1;
        // Start a count with ws=5 then pull reset between edges.
        valid_access5 = 1; ws_enable5 = 1; wsr_cfg5 = 8'd5; csle_cfg5 = 2'd3; oete_cfg5 = 2'd2;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (r_ws_count5 !== 8'd4) begin
            failures++;
            $display("FAIL reset_precount ws actual=%0d expected=4", r_ws_count5);
        end
        #2;
        n_sys_reset5 = 0;
        model_clear();
        #1;
        checks++;
        if (act_vec() !== 16'h0) begin
            failures++;
            $display("FAIL reset_async actual=%h expected=0000", act_vec());
        end
        tick();
        n_sys_reset5 = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (act_vec() !== 16'h0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d actual=%h expected=0000", i, act_vec());
            end
        end
    endtask

    task automatic test_read();
        int exp_csle[3] = '{2, 1, 0};
        int exp_ws[4]   = '{3, 2, 1, 0};
        idle_inputs();
        valid_access5 = 1; n_read5 = 0;
        csle_cfg5 = 2; cste_cfg5 = 1; oete_cfg5 = 3; wsr_cfg5 = 3; wsw_cfg5 = 7;
        tick();
        valid_access5 = 0; le_enable5 = 1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (r_csle_count5 !== 2'(exp_csle[i]) || act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL read_csle step=%0d actual=%0d expected=%0d vec=%h model=%h",
                         i, r_csle_count5, exp_csle[i], act_vec(), exp_vec());
            end
            if (i < 2) tick();
        end
        checks++;
        if (r_csle_store5 !== 2'd2 || r_oete_store5 !== 2'd3) begin
            failures++;
            $display("FAIL read_stores actual=%0d/%0d expected=2/3", r_csle_store5, r_oete_store5);
        end
        le_enable5 = 0; ws_enable5 = 1;
        tick();
        ws_enable5 = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (r_ws_count5 !== 8'(exp_ws[i]) || r_cste_count5 !== 2'd1) begin
                failures++;
                $display("FAIL read_ws step=%0d actual=%0d expected=%0d cste=%0d",
                         i, r_ws_count5, exp_ws[i], r_cste_count5);
            end
            tick();
        end
        cste_enable5 = 1;
        tick();
        cste_enable5 = 0;
        checks++;
        if (r_cste_count5 !== 2'd0 || act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL read_cste actual=%0d expected=0", r_cste_count5);
        end
    endtask

    task automatic test_write();
        idle_inputs();
        valid_access5 = 1; ws_enable5 = 1; n_read5 = 1; wsr_cfg5 = 9; wsw_cfg5 = 4;
        tick();
        idle_inputs();
        checks++;
        if (r_ws_count5 !== 8'd4) begin
            failures++;
            $display("FAIL write_ws actual=%0d expected=4", r_ws_count5);
        end
        tick(); tick();
        wsw_cfg5 = 8'd200; wsr_cfg5 = 8'd100;
        ws_enable5 = 1;
        tick();
        ws_enable5 = 0;
        checks++;
        if (r_ws_count5 !== 8'd4) begin
            failures++;
            $display("FAIL write_reload actual=%0d expected=4", r_ws_count5);
        end
    endtask

    task automatic test_mac();
        idle_inputs();
        valid_access5 = 1; csle_cfg5 = 1; cste_cfg5 = 2;
        tick();
        valid_access5 = 0; le_enable5 = 1; cste_enable5 = 1;
        tick(); tick(); tick();
        le_enable5 = 0; cste_enable5 = 0;
        smc_done5 = 1; mac_done5 = 0;
        tick();
        smc_done5 = 0;
        checks++;
        if (r_csle_count5 !== 2'd1 || r_cste_count5 !== 2'd2) begin
            failures++;
            $display("FAIL mac_reload actual=%0d/%0d expected=1/2", r_csle_count5, r_cste_count5);
        end
        le_enable5 = 1; cste_enable5 = 1;
        tick(); tick(); tick();
        le_enable5 = 0; cste_enable5 = 0;
        smc_done5 = 1; mac_done5 = 1;
        tick();
        smc_done5 = 0; mac_done5 = 0;
        tick();
        checks++;
        if (r_csle_count5 !== 2'd0 || r_cste_count5 !== 2'd0) begin
            failures++;
            $display("FAIL mac_last actual=%0d/%0d expected=0/0", r_csle_count5, r_cste_count5);
        end
    endtask

    task automatic test_collision();
        idle_inputs();
        valid_access5 = 1; csle_cfg5 = 1;
        tick();
        valid_access5 = 0; le_enable5 = 1;
        tick();
        le_enable5 = 0;
        valid_access5 = 1; smc_done5 = 1; mac_done5 = 0; csle_cfg5 = 3;
        tick();
        idle_inputs();
        checks++;
        if (r_csle_count5 !== 2'd3 || r_csle_store5 !== 2'd3) begin
            failures++;
            $display("FAIL collision actual=%0d store=%0d expected=3", r_csle_count5, r_csle_store5);
        end
    endtask

`ifdef SMC_EXT_WAIT_EN
    task automatic test_ext_wait();
        int exp_ws[6] = '{3, 2, 1, 1, 1, 1};
        idle_inputs();
        valid_access5 = 1; ws_enable5 = 1; wsr_cfg5 = 3; n_read5 = 0;
        smc_n_ext_wait5 = 0;
        tick();
        valid_access5 = 0; ws_enable5 = 0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (r_ws_count5 !== 8'(exp_ws[i])) begin
                failures++;
                $display("FAIL ext_wait step=%0d actual=%0d expected=%0d", i, r_ws_count5, exp_ws[i]);
            end
            if (i == 5) smc_n_ext_wait5 = 1;
            tick();
        end
        checks++;
        if (r_ws_count5 !== 8'd0) begin
            failures++;
            $display("FAIL ext_release actual=%0d expected=0", r_ws_count5);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            valid_access5   = ($urandom_range(0, 7) == 0);
            le_enable5      = $urandom_range(0, 1);
            ws_enable5      = ($urandom_range(0, 9) == 0);
            cste_enable5    = $urandom_range(0, 1);
            smc_done5       = ($urandom_range(0, 5) == 0);
            mac_done5       = $urandom_range(0, 1);
            n_read5         = $urandom_range(0, 1);
            smc_n_ext_wait5 = ($urandom_range(0, 3) != 0);
            csle_cfg5       = 2'($urandom);
            cste_cfg5       = 2'($urandom);
            oete_cfg5       = 2'($urandom);
            wsr_cfg5        = 8'($urandom_range(0, 12));
            wsw_cfg5        = (i % 50 == 0) ? 8'hFF : 8'($urandom_range(0, 12));
            if (i == 300) begin
                #2 n_sys_reset5 = 0;
                model_clear();
                #1;
                checks++;
                if (act_vec() !== 16'h0) begin
                    failures++;
                    $display("FAIL rand_reset actual=%h expected=0000", act_vec());
                end
                tick();
                n_sys_reset5 = 1;
            end
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc=%0d actual=%h expected=%h", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_mac();
        test_collision();
`ifdef SMC_EXT_WAIT_EN
        test_ext_wait();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
